// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port memory bank.
package mem_pkg;

  typedef enum logic {CLEAR, RUN} mem_state_t;

  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/memory_lane.sv
// One byte lane of the bank: 8-bit x DEPTH array, one write port, two read ports.
// Reads are combinational so the caller sees pre-write contents in the write cycle.
module memory_lane
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  output logic [7:0]            o_a_rdata,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [7:0]            o_b_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_a_rdata = r_mem[i_a_addr];
  assign o_b_rdata = r_mem[i_b_addr];

endmodule

// File: rtl/dual_port_memory_bank.sv
// Byte-maskable dual-port RAM bank: port A read-only fetch, port B masked load/store.
// Optional macro MEM_COLLISION_BYPASS_EN forwards a same-cycle B write to an A read.
module dual_port_memory_bank
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    a_req_valid,
  output logic                    a_req_ready,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  output logic                    a_rsp_valid,
  output logic                    a_rsp_err,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_req_valid,
  output logic                    b_req_ready,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH/8-1:0] b_wmask,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_rsp_valid,
  output logic                    b_rsp_err,
  output logic [DATA_WIDTH-1:0]   b_rdata
);

  localparam int                    LANES     = lanes(DATA_WIDTH);
  localparam int                    LAST_I    = DEPTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = LAST_I[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = DEPTH[ADDR_WIDTH:0];

  mem_state_t            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt, w_clr_cnt_nxt;

  logic                  w_a_acc, w_b_acc, w_a_inr, w_b_inr, w_b_wr;
  logic [LANES-1:0]      w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata, w_a_word, w_b_word, w_a_fwd;

  logic                  r_a_rsp_valid, r_a_rsp_err, r_b_rsp_valid, r_b_rsp_err;
  logic [DATA_WIDTH-1:0] r_a_rdata, r_b_rdata;

  assign init_busy   = (r_state == CLEAR);
  assign a_req_ready = (r_state == RUN);
  assign b_req_ready = (r_state == RUN);

  assign w_a_acc = a_req_valid & a_req_ready;
  assign w_b_acc = b_req_valid & b_req_ready;
  assign w_a_inr = ({1'b0, a_addr} < DEPTH_L);
  assign w_b_inr = ({1'b0, b_addr} < DEPTH_L);
  assign w_b_wr  = w_b_acc & w_b_inr & (|b_wmask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    if (r_state == CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (r_clr_cnt == LAST_ADDR) w_state_nxt = RUN;
    end
  end

  // The single write port belongs to the clear sequencer until the array is zeroed.
  always_comb begin
    w_we    = '0;
    w_waddr = b_addr;
    w_wdata = b_wdata;
    if (r_state == CLEAR) begin
      w_we    = '1;
      w_waddr = r_clr_cnt;
      w_wdata = '0;
    end else if (w_b_wr) begin
      w_we    = b_wmask;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    memory_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_lane (
      .clk       (clk),
      .i_we      (w_we[g]),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata[8*g +: 8]),
      .i_a_addr  (a_addr),
      .o_a_rdata (w_a_word[8*g +: 8]),
      .i_b_addr  (b_addr),
      .o_b_rdata (w_b_word[8*g +: 8])
    );
  end

  always_comb begin
    w_a_fwd = w_a_word;
`ifdef MEM_COLLISION_BYPASS_EN
    if (w_a_acc && w_b_wr && (a_addr == b_addr)) begin
      for (int i = 0; i < LANES; i++) begin
        if (b_wmask[i]) w_a_fwd[8*i +: 8] = b_wdata[8*i +: 8];
      end
    end
`endif
  end

  // Response stage: data and error only update on an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rsp_valid <= 1'b0;
      r_a_rsp_err   <= 1'b0;
      r_a_rdata     <= '0;
      r_b_rsp_valid <= 1'b0;
      r_b_rsp_err   <= 1'b0;
      r_b_rdata     <= '0;
    end else begin
      r_a_rsp_valid <= w_a_acc;
      r_b_rsp_valid <= w_b_acc;
      if (w_a_acc) begin
        r_a_rsp_err <= ~w_a_inr;
        r_a_rdata   <= w_a_inr ? w_a_fwd : '0;
      end
      if (w_b_acc) begin
        r_b_rsp_err <= ~w_b_inr;
        r_b_rdata   <= w_b_inr ? w_b_word : '0;
      end
    end
  end

  assign a_rsp_valid = r_a_rsp_valid;
  assign a_rsp_err   = r_a_rsp_err;
  assign a_rdata     = r_a_rdata;
  assign b_rsp_valid = r_b_rsp_valid;
  assign b_rsp_err   = r_b_rsp_err;
  assign b_rdata     = r_b_rdata;

endmodule

// File: tb/tb_dual_port_memory_bank.sv
// Directed bench for dual_port_memory_bank: a DEPTH=16 instance with a response
// scoreboard, and a DEPTH=12 instance for out-of-range addresses.
module tb_dual_port_memory_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        init_busy, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
  logic [3:0]  a_addr, b_addr, b_wmask;
  logic [31:0] a_rdata, b_wdata, b_rdata;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;

  logic        x_init_busy, x_a_req_valid, x_a_req_ready, x_a_rsp_valid, x_a_rsp_err;
  logic [3:0]  x_a_addr, x_b_addr, x_b_wmask;
  logic [31:0] x_a_rdata, x_b_wdata, x_b_rdata;
  logic        x_b_req_valid, x_b_req_ready, x_b_rsp_valid, x_b_rsp_err;

  dual_port_memory_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
    .a_rsp_valid(a_rsp_valid), .a_rsp_err(a_rsp_err), .a_rdata(a_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr),
    .b_wmask(b_wmask), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_err(b_rsp_err), .b_rdata(b_rdata)
  );

  dual_port_memory_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .init_busy(x_init_busy),
    .a_req_valid(x_a_req_valid), .a_req_ready(x_a_req_ready), .a_addr(x_a_addr),
    .a_rsp_valid(x_a_rsp_valid), .a_rsp_err(x_a_rsp_err), .a_rdata(x_a_rdata),
    .b_req_valid(x_b_req_valid), .b_req_ready(x_b_req_ready), .b_addr(x_b_addr),
    .b_wmask(x_b_wmask), .b_wdata(x_b_wdata),
    .b_rsp_valid(x_b_rsp_valid), .b_rsp_err(x_b_rsp_err), .b_rdata(x_b_rdata)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model [16];
  logic [31:0] last_a, last_b;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"},    32'(init_busy),   32'd1);
    chk({tag, ".a_rdy"},   32'(a_req_ready), 32'd0);
    chk({tag, ".b_rdy"},   32'(b_req_ready), 32'd0);
    chk({tag, ".a_vld"},   32'(a_rsp_valid), 32'd0);
    chk({tag, ".b_vld"},   32'(b_rsp_valid), 32'd0);
    chk({tag, ".a_err"},   32'(a_rsp_err),   32'd0);
    chk({tag, ".b_err"},   32'(b_rsp_err),   32'd0);
    chk({tag, ".a_rdata"}, a_rdata,          32'd0);
    chk({tag, ".b_rdata"}, b_rdata,          32'd0);
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk({e.tag, ".a_vld"},   32'(a_rsp_valid), 32'd1);
      chk({e.tag, ".a_rdata"}, a_rdata,          e.data);
      chk({e.tag, ".a_err"},   32'(a_rsp_err),   32'(e.err));
      last_a = e.data;
    end else begin
      chk("a_idle_vld",  32'(a_rsp_valid), 32'd0);
      chk("a_idle_hold", a_rdata,          last_a);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk({e.tag, ".b_vld"},   32'(b_rsp_valid), 32'd1);
      chk({e.tag, ".b_rdata"}, b_rdata,          e.data);
      chk({e.tag, ".b_err"},   32'(b_rsp_err),   32'(e.err));
      last_b = e.data;
    end else begin
      chk("b_idle_vld",  32'(b_rsp_valid), 32'd0);
      chk("b_idle_hold", b_rdata,          last_b);
    end
  endtask

  task automatic req(input string tag, input logic av, input logic [3:0] aa,
                     input logic bv, input logic [3:0] ba, input logic [3:0] bm,
                     input logic [31:0] bd);
    exp_t ea, eb;
    logic [31:0] bnew;
    a_req_valid = av; a_addr = aa;
    b_req_valid = bv; b_addr = ba; b_wmask = bm; b_wdata = bd;
    ea.tag = tag; ea.err = 1'b0; ea.data = model[aa];
    eb.tag = tag; eb.err = 1'b0; eb.data = model[ba];
    if (bv) begin
      bnew = merge(model[ba], bm, bd);
`ifdef MEM_COLLISION_BYPASS_EN
      if (av && aa == ba && bm != 4'b0000) ea.data = bnew;
`endif
      model[ba] = bnew;
      qb.push_back(eb);
    end
    if (av) qa.push_back(ea);
    tick();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    b_wmask     = 4'b0000;
  endtask

  task automatic x_tick(input string tag, input logic port_b, input logic [31:0] d,
                        input logic e);
    @(posedge clk);
    #1;
    x_a_req_valid = 1'b0;
    x_b_req_valid = 1'b0;
    if (port_b) begin
      chk({tag, ".vld"},   32'(x_b_rsp_valid), 32'd1);
      chk({tag, ".rdata"}, x_b_rdata,          d);
      chk({tag, ".err"},   32'(x_b_rsp_err),   32'(e));
    end else begin
      chk({tag, ".vld"},   32'(x_a_rsp_valid), 32'd1);
      chk({tag, ".rdata"}, x_a_rdata,          d);
      chk({tag, ".err"},   32'(x_a_rsp_err),   32'(e));
    end
  endtask

  initial begin
    a_req_valid = 0; a_addr = 0; b_req_valid = 0; b_addr = 0; b_wmask = 0; b_wdata = 0;
    x_a_req_valid = 0; x_a_addr = 0; x_b_req_valid = 0; x_b_addr = 0;
    x_b_wmask = 0; x_b_wdata = 0;
    last_a = '0; last_b = '0;

    #1;
    chk_reset("rst0");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: hold both ports valid through the clear sequence
    a_req_valid = 1; a_addr = 4'd5; b_req_valid = 1; b_addr = 4'd2; b_wmask = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("clr%0d.busy", k),  32'(init_busy),   32'd1);
      chk($sformatf("clr%0d.a_rdy", k), 32'(a_req_ready), 32'd0);
      chk($sformatf("clr%0d.b_rdy", k), 32'(b_req_ready), 32'd0);
      chk($sformatf("clr%0d.a_vld", k), 32'(a_rsp_valid), 32'd0);
      chk($sformatf("clr%0d.busy12", k), 32'(x_init_busy), 32'(k < 12));
      @(posedge clk); #1;
    end
    chk("clr16.busy",  32'(init_busy),   32'd0);
    chk("clr16.a_rdy", 32'(a_req_ready), 32'd1);
    chk("clr16.b_rdy", 32'(b_req_ready), 32'd1);
    chk("clr16.a_vld", 32'(a_rsp_valid), 32'd0);
    req("t1_rd5", 1, 4'd5, 1, 4'd2, 4'b0000, 32'h0);
    tick();

    // 2/3: masked writes with back-to-back reads on port B
    req("t2_wr0",   0, 4'd0, 1, 4'd0, 4'b1111, 32'h77ff8855);
    req("t2_rd0",   0, 4'd0, 1, 4'd0, 4'b0000, 32'h0);
    req("t3_wr0",   0, 4'd0, 1, 4'd0, 4'b0101, 32'hAABBCCDD);
    req("t3_rd0",   1, 4'd0, 1, 4'd0, 4'b0000, 32'h0);
    chk("t3_const", b_rdata, 32'h77BB88DD);
    tick();

    // 4: same-cycle A read / B write collision
    req("t4_coll",  1, 4'd3, 1, 4'd3, 4'b1111, 32'h12345678);
    req("t4_after", 1, 4'd3, 1, 4'd3, 4'b0000, 32'h0);
    req("t4_pcoll", 1, 4'd7, 1, 4'd7, 4'b0011, 32'hCAFEF00D);
    req("t4_split", 1, 4'd7, 1, 4'd3, 4'b0000, 32'h0);
    req("t4_b15",   1, 4'd14, 1, 4'd15, 4'b1000, 32'h5A000000);
    req("t4_r15",   1, 4'd15, 0, 4'd0, 4'b0000, 32'h0);
    tick();

    // 5: out-of-range handling on the DEPTH=12 instance
    x_b_req_valid = 1; x_b_addr = 4'd11; x_b_wmask = 4'b1111; x_b_wdata = 32'h11223344;
    x_tick("t5_wr11", 1, 32'h0, 0);
    x_b_req_valid = 1; x_b_addr = 4'd11; x_b_wmask = 4'b0000;
    x_tick("t5_rd11", 1, 32'h11223344, 0);
    x_b_req_valid = 1; x_b_addr = 4'd13; x_b_wmask = 4'b1111; x_b_wdata = 32'hDEADBEEF;
    x_tick("t5_wr13", 1, 32'h0, 1);
    x_a_req_valid = 1; x_a_addr = 4'd11;
    x_tick("t5_ard11", 0, 32'h11223344, 0);
    x_a_req_valid = 1; x_a_addr = 4'd13;
    x_tick("t5_ard13", 0, 32'h0, 1);
    x_b_req_valid = 1; x_b_addr = 4'd12; x_b_wmask = 4'b0000;
    x_tick("t5_brd12", 1, 32'h0, 1);

    // 6: reset from RUN, then reset again in the middle of the clear
    req("t6_pre", 1, 4'd0, 1, 4'd7, 4'b0000, 32'h0);
    rst = 1'b1;
    #1;
    chk_reset("rst_run");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("mid%0d.busy", k), 32'(init_busy), 32'd1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rclr%0d.busy", k),  32'(init_busy),   32'd1);
      chk($sformatf("rclr%0d.a_rdy", k), 32'(a_req_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("rclr16.busy", 32'(init_busy), 32'd0);
    req("t6_rd15", 1, 4'd15, 1, 4'd0, 4'b0000, 32'h0);
    req("t6_rd7",  1, 4'd7,  1, 4'd3, 4'b0000, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
